// File: rtl/segment_txt_scroll_if.sv
// Bus between the text writer and the display driver.
//
// Handshake: the write port has no ready signal. Every cycle in which
// i_wr_en is high is one accepted write of i_wr_char to i_wr_addr.
// i_len and i_scroll are level controls sampled every clock. The display
// outputs are free-running and take no backpressure. dbg_* expose the
// scroll offset and the lit digit index for monitoring.
interface segment_txt_scroll_if #(
  parameter int DIGITS  = 8,
  parameter int BUF_LEN = 16
);
  localparam int AW = $clog2(BUF_LEN);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              i_wr_en;
  logic [AW-1:0]     i_wr_addr;
  logic [5:0]        i_wr_char;
  logic [AW:0]       i_len;
  logic              i_scroll;
  logic [6:0]        o_seg;
  logic [DIGITS-1:0] o_an;
  logic              o_frame;
  logic              o_wrap;
  logic [AW-1:0]     dbg_offset;
  logic [DW-1:0]     dbg_digit;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_char, i_len, i_scroll,
    input  o_seg, o_an, o_frame, o_wrap, dbg_offset, dbg_digit
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_char, i_len, i_scroll,
    output o_seg, o_an, o_frame, o_wrap, dbg_offset, dbg_digit
  );
endinterface

// File: rtl/segment_txt_scroll.sv
// Time-multiplexed multi-digit 7-segment text driver with a character
// buffer, a refresh scan with an anti-ghost blank clock per slot, and an
// optional scrolling window over the buffer.
module segment_txt_scroll #(
  parameter int DIGITS         = 8,
  parameter int BUF_LEN        = 16,
  parameter int REFRESH_DIV    = 50000,
  parameter int SCROLL_FRAMES  = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic           i_clk,
  input logic           i_rst_n,
  segment_txt_scroll_if.slave bus
);

  localparam int AW = $clog2(BUF_LEN);
  localparam int LW = AW + 1;
  localparam int CW = LW + 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [5:0]        BLANK   = 6'h3F;
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Glyph table, active-low, bit 0 = top ... bit 6 = middle.
  function automatic logic [6:0] glyph(input logic [5:0] c);
    logic [6:0] g;
    case (c)
      6'h00: g = 7'h40;  // 0
      6'h01: g = 7'h79;  // 1
      6'h02: g = 7'h24;  // 2
      6'h03: g = 7'h30;  // 3
      6'h04: g = 7'h19;  // 4
      6'h05: g = 7'h12;  // 5
      6'h06: g = 7'h02;  // 6
      6'h07: g = 7'h78;  // 7
      6'h08: g = 7'h00;  // 8
      6'h09: g = 7'h10;  // 9
      6'h0A: g = 7'h08;  // A
      6'h0B: g = 7'h03;  // b
      6'h0C: g = 7'h46;  // C
      6'h0D: g = 7'h21;  // d
      6'h0E: g = 7'h06;  // E
      6'h0F: g = 7'h0E;  // F
      6'h10: g = 7'h42;  // G
      6'h11: g = 7'h0B;  // h
      6'h12: g = 7'h4F;  // I
      6'h13: g = 7'h61;  // J
      6'h14: g = 7'h0A;  // K
      6'h15: g = 7'h47;  // L
      6'h16: g = 7'h6A;  // M
      6'h17: g = 7'h2B;  // n
      6'h18: g = 7'h23;  // o
      6'h19: g = 7'h0C;  // P
      6'h1A: g = 7'h18;  // q
      6'h1B: g = 7'h2F;  // r
      6'h1C: g = 7'h12;  // S
      6'h1D: g = 7'h07;  // t
      6'h1E: g = 7'h41;  // U
      6'h1F: g = 7'h63;  // v
      6'h20: g = 7'h55;  // W
      6'h21: g = 7'h09;  // X
      6'h22: g = 7'h11;  // y
      6'h23: g = 7'h24;  // Z
      6'h24: g = 7'h3F;  // -
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  logic [5:0]        text_q [BUF_LEN];
  logic [SW-1:0]     slot_cnt;
  logic [DW-1:0]     digit_idx;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [AW-1:0]     offset_q, offset_d;
  logic              wrap_d;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] an_q;
  logic              frame_q;
  logic              wrap_q;

  logic [LW-1:0]     eff_len;
  logic              slot_last;
  logic              digit_last;
  logic              frame_tick;
  logic [CW-1:0]     len_x;
  logic [CW-1:0]     d_mod;
  logic [CW-1:0]     sum;
  logic [AW-1:0]     rd_idx;
  logic [5:0]        cur_char;
  logic [DIGITS-1:0] an_sel;

  // Clamp the requested length to the buffer and decode scan boundaries.
  always_comb begin
    eff_len    = (bus.i_len > LW'(BUF_LEN)) ? LW'(BUF_LEN) : bus.i_len;
    slot_last  = (slot_cnt == SW'(REFRESH_DIV - 1));
    digit_last = (digit_idx == DW'(DIGITS - 1));
    frame_tick = slot_last && digit_last;
  end

  // Slot counter and digit index; the digit advances on slot terminal count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
      if (slot_last) begin
        digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
      end
    end
  end

  // Text buffer; writes beyond the buffer are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_LEN; i++) begin
        text_q[i] <= BLANK;
      end
    end else if (bus.i_wr_en && ({1'b0, bus.i_wr_addr} < LW'(BUF_LEN))) begin
      text_q[bus.i_wr_addr] <= bus.i_wr_char;
    end
  end

  // Character for the current digit. The digit index is reduced modulo L by
  // a short chain of conditional subtractions (long enough for texts shorter
  // than the display), then the offset is added and reduced once more.
  always_comb begin
    len_x = CW'(eff_len);
    d_mod = CW'(digit_idx);
    for (int i = 0; i < DIGITS; i++) begin
      if ((len_x != '0) && (d_mod >= len_x)) begin
        d_mod = d_mod - len_x;
      end
    end
    sum = CW'(offset_q) + d_mod;
    if ((len_x != '0) && (sum >= len_x)) begin
      sum = sum - len_x;
    end
    rd_idx   = AW'(sum);
    cur_char = BLANK;
    if (!bus.i_scroll) begin
      if (CW'(digit_idx) < len_x) begin
        cur_char = text_q[AW'(digit_idx)];
      end
    end else if (len_x != '0) begin
      cur_char = text_q[rd_idx];
    end
  end

  // Scroll next state: held at 0 in static mode or empty text, cleared when
  // the length shrinks under the offset, stepped only on frame boundaries.
  always_comb begin
    offset_d = offset_q;
    fcnt_d   = fcnt_q;
    wrap_d   = 1'b0;
    if (!bus.i_scroll || (eff_len == '0)) begin
      offset_d = '0;
      fcnt_d   = '0;
    end else if ({1'b0, offset_q} >= eff_len) begin
      offset_d = '0;
    end else if (frame_tick) begin
      if (fcnt_q == FW'(SCROLL_FRAMES - 1)) begin
        fcnt_d = '0;
        if (({1'b0, offset_q} + LW'(1)) >= eff_len) begin
          offset_d = '0;
          wrap_d   = (offset_q != '0);
        end else begin
          offset_d = offset_q + 1'b1;
        end
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Scroll state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      offset_q <= '0;
      fcnt_q   <= '0;
    end else begin
      offset_q <= offset_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // One-hot select of the digit being scanned.
  always_comb begin
    an_sel            = '0;
    an_sel[digit_idx] = 1'b1;
  end

  // Output registers: anodes off on the first clock of a slot, segments and
  // anode latched together on the second clock and held to the slot end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      frame_q <= frame_tick;
      wrap_q  <= wrap_d;
      if (slot_last) begin
        an_q <= AN_OFF;
      end else if (slot_cnt == '0) begin
        an_q  <= AN_ACTIVE_LOW ? ~an_sel : an_sel;
        seg_q <= SEG_ACTIVE_LOW ? glyph(cur_char) : ~glyph(cur_char);
      end
    end
  end

  assign bus.o_seg      = seg_q;
  assign bus.o_an       = an_q;
  assign bus.o_frame    = frame_q;
  assign bus.o_wrap     = wrap_q;
  assign bus.dbg_offset = offset_q;
  assign bus.dbg_digit  = digit_idx;

endmodule

// File: tb/tb_segment_txt_scroll.sv
// Directed bench for segment_txt_scroll: a 4-digit, 6-character instance
// with active-low outputs and a second one with active-high outputs.
module tb_segment_txt_scroll;

  localparam int DIGITS        = 4;
  localparam int BUF_LEN       = 6;
  localparam int REFRESH_DIV   = 4;
  localparam int SCROLL_FRAMES = 1;

  localparam logic [6:0] G_H = 7'h0B;
  localparam logic [6:0] G_E = 7'h06;
  localparam logic [6:0] G_L = 7'h47;
  localparam logic [6:0] G_P = 7'h0C;
  localparam logic [6:0] BLK = 7'h7F;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] dig_seg  [6] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
  logic [6:0] help_seg [4] = '{G_H, G_E, G_L, G_P};

  // Clock and reset
  always #5 clk = ~clk;

  segment_txt_scroll_if #(.DIGITS(DIGITS), .BUF_LEN(BUF_LEN)) bus_a ();
  segment_txt_scroll_if #(.DIGITS(DIGITS), .BUF_LEN(BUF_LEN)) bus_b ();

  segment_txt_scroll #(
    .DIGITS(DIGITS), .BUF_LEN(BUF_LEN), .REFRESH_DIV(REFRESH_DIV),
    .SCROLL_FRAMES(SCROLL_FRAMES), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a.slave)
  );

  segment_txt_scroll #(
    .DIGITS(DIGITS), .BUF_LEN(BUF_LEN), .REFRESH_DIV(REFRESH_DIV),
    .SCROLL_FRAMES(SCROLL_FRAMES), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b.slave)
  );

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus_a.i_wr_en = 1'b0; bus_a.i_wr_addr = '0; bus_a.i_wr_char = '0;
    bus_a.i_len   = '0;   bus_a.i_scroll  = 1'b0;
    bus_b.i_wr_en = 1'b0; bus_b.i_wr_addr = '0; bus_b.i_wr_char = '0;
    bus_b.i_len   = '0;   bus_b.i_scroll  = 1'b0;
  endtask

  task automatic write_a(input logic [2:0] a, input logic [5:0] c);
    bus_a.i_wr_en = 1'b1; bus_a.i_wr_addr = a; bus_a.i_wr_char = c;
    step(1);
    bus_a.i_wr_en = 1'b0;
  endtask

  task automatic write_b(input logic [2:0] a, input logic [5:0] c);
    bus_b.i_wr_en = 1'b1; bus_b.i_wr_addr = a; bus_b.i_wr_char = c;
    step(1);
    bus_b.i_wr_en = 1'b0;
  endtask

  // Advance to the cycle carrying o_frame; bounded.
  task automatic sync_frame(input bit use_b);
    bit got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      step(1);
      got = use_b ? bus_b.o_frame : bus_a.o_frame;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL sync_frame: o_frame seen=%0d required=1 within 64 clocks", got);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_a.o_an, bus_a.o_seg, bus_a.o_frame, bus_a.o_wrap} !== {4'hF, 7'h7F, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_async_a: an/seg/frame/wrap=%b required=%b",
               {bus_a.o_an, bus_a.o_seg, bus_a.o_frame, bus_a.o_wrap}, {4'hF, 7'h7F, 2'b00});
    end
    n_cmp++;
    if ({bus_b.o_an, bus_b.o_seg} !== {4'h0, 7'h00}) begin
      n_bad++;
      $display("FAIL reset_async_b: an/seg=%b required=%b", {bus_b.o_an, bus_b.o_seg}, {4'h0, 7'h00});
    end
    step(2);
    rst_n = 1'b1;
    n_cmp++;
    if (bus_a.o_an !== 4'hF) begin
      n_bad++;
      $display("FAIL reset_release_blank: an=%b required=1111", bus_a.o_an);
    end
    step(1);
    n_cmp++;
    if ({bus_a.o_an, bus_a.o_seg} !== {4'b1110, BLK}) begin
      n_bad++;
      $display("FAIL reset_first_slot_a: an/seg=%b required=%b", {bus_a.o_an, bus_a.o_seg}, {4'b1110, BLK});
    end
    n_cmp++;
    if ({bus_b.o_an, bus_b.o_seg} !== {4'b0001, 7'h00}) begin
      n_bad++;
      $display("FAIL reset_first_slot_b: an/seg=%b required=%b", {bus_b.o_an, bus_b.o_seg}, {4'b0001, 7'h00});
    end
    step(12);
    n_cmp++;
    if (bus_a.o_an !== 4'b0111) begin
      n_bad++;
      $display("FAIL reset_digit3_lit: an=%b required=0111", bus_a.o_an);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_a.o_an, bus_a.o_seg} !== {4'hF, 7'h7F}) begin
      n_bad++;
      $display("FAIL reset_mid_scan: an/seg=%b required=%b", {bus_a.o_an, bus_a.o_seg}, {4'hF, 7'h7F});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_static_help();
    logic [3:0] exp_an;
    write_a(3'd0, 6'h11);
    write_a(3'd1, 6'h0E);
    write_a(3'd2, 6'h15);
    write_a(3'd3, 6'h19);
    bus_a.i_len = 4'd4;
    sync_frame(1'b0);
    n_cmp++;
    if (bus_a.o_an !== 4'hF) begin
      n_bad++;
      $display("FAIL help_frame_start_blank: an=%b required=1111", bus_a.o_an);
    end
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      for (int k = 1; k <= 4; k++) begin
        step(1);
        n_cmp++;
        if (k < 4) begin
          if ({bus_a.o_an, bus_a.o_seg, bus_a.o_frame} !== {exp_an, help_seg[d], 1'b0}) begin
            n_bad++;
            $display("FAIL help_lit d%0d k%0d: an/seg/frame=%b required=%b", d, k,
                     {bus_a.o_an, bus_a.o_seg, bus_a.o_frame}, {exp_an, help_seg[d], 1'b0});
          end
        end else if ({bus_a.o_an, bus_a.o_frame} !== {4'hF, (d == 3)}) begin
          n_bad++;
          $display("FAIL help_slot_end d%0d: an/frame=%b required=%b", d,
                   {bus_a.o_an, bus_a.o_frame}, {4'hF, (d == 3)});
        end
      end
    end
  endtask

  task automatic test_static_short();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    bus_a.i_len = 4'd2;
    sync_frame(1'b0);
    for (int fr = 0; fr < 2; fr++) begin
      for (int d = 0; d < 4; d++) begin
        exp_an  = ~(4'b0001 << d);
        exp_seg = (d == 0) ? ((fr == 0) ? G_H : BLK) : ((d == 1) ? G_E : BLK);
        for (int k = 1; k <= 4; k++) begin
          step(1);
          n_cmp++;
          if (k < 4) begin
            if ({bus_a.o_an, bus_a.o_seg} !== {exp_an, exp_seg}) begin
              n_bad++;
              $display("FAIL short_lit f%0d d%0d k%0d: an/seg=%b required=%b", fr, d, k,
                       {bus_a.o_an, bus_a.o_seg}, {exp_an, exp_seg});
            end
          end else if (bus_a.o_an !== 4'hF) begin
            n_bad++;
            $display("FAIL short_slot_end f%0d d%0d: an=%b required=1111", fr, d, bus_a.o_an);
          end
          if (fr == 0 && d == 0 && k == 1) begin
            bus_a.i_wr_en = 1'b1; bus_a.i_wr_addr = 3'd0; bus_a.i_wr_char = 6'h2A;
          end
          if (fr == 0 && d == 0 && k == 2) bus_a.i_wr_en = 1'b0;
        end
      end
    end
  endtask

  task automatic test_scroll();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int i = 0; i < 6; i++) write_a(3'(i), 6'(i));
    bus_a.i_len = 4'd6;
    sync_frame(1'b0);
    bus_a.i_scroll = 1'b1;
    for (int f = 0; f < 7; f++) begin
      for (int d = 0; d < 4; d++) begin
        exp_an  = ~(4'b0001 << d);
        exp_seg = dig_seg[(f + d) % 6];
        for (int k = 1; k <= 4; k++) begin
          step(1);
          n_cmp++;
          if (k < 4) begin
            if ({bus_a.o_an, bus_a.o_seg, bus_a.o_wrap} !== {exp_an, exp_seg, 1'b0}) begin
              n_bad++;
              $display("FAIL scroll_lit f%0d d%0d k%0d: an/seg/wrap=%b required=%b", f, d, k,
                       {bus_a.o_an, bus_a.o_seg, bus_a.o_wrap}, {exp_an, exp_seg, 1'b0});
            end
          end else if ({bus_a.o_an, bus_a.o_frame, bus_a.o_wrap} !==
                       {4'hF, (d == 3), (f == 5 && d == 3)}) begin
            n_bad++;
            $display("FAIL scroll_slot_end f%0d d%0d: an/frame/wrap=%b required=%b", f, d,
                     {bus_a.o_an, bus_a.o_frame, bus_a.o_wrap}, {4'hF, (d == 3), (f == 5 && d == 3)});
          end
        end
      end
    end
  endtask

  task automatic test_shrink();
    logic [3:0] exp_an;
    step(64);
    n_cmp++;
    if ({bus_a.dbg_offset, bus_a.o_frame} !== {3'd5, 1'b1}) begin
      n_bad++;
      $display("FAIL shrink_offset5: offset/frame=%b required=%b", {bus_a.dbg_offset, bus_a.o_frame}, {3'd5, 1'b1});
    end
    step(2);
    n_cmp++;
    if (bus_a.o_seg !== dig_seg[5]) begin
      n_bad++;
      $display("FAIL shrink_digit0_at5: seg=%b required=%b", bus_a.o_seg, dig_seg[5]);
    end
    bus_a.i_len = 4'd3;
    step(1);
    n_cmp++;
    if ({bus_a.dbg_offset, bus_a.o_wrap} !== {3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL shrink_clear: offset/wrap=%b required=%b", {bus_a.dbg_offset, bus_a.o_wrap}, {3'd0, 1'b0});
    end
    for (int d = 1; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      for (int k = 1; k <= 4; k++) begin
        step(1);
        n_cmp++;
        if (k == 1) begin
          if ({bus_a.o_an, bus_a.o_wrap} !== {4'hF, 1'b0}) begin
            n_bad++;
            $display("FAIL shrink_gap d%0d: an/wrap=%b required=%b", d, {bus_a.o_an, bus_a.o_wrap}, {4'hF, 1'b0});
          end
        end else if ({bus_a.o_an, bus_a.o_seg} !== {exp_an, dig_seg[d % 3]}) begin
          n_bad++;
          $display("FAIL shrink_lit d%0d k%0d: an/seg=%b required=%b", d, k,
                   {bus_a.o_an, bus_a.o_seg}, {exp_an, dig_seg[d % 3]});
        end
      end
    end
    step(1);
    n_cmp++;
    if ({bus_a.dbg_offset, bus_a.o_frame, bus_a.o_wrap} !== {3'd1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL shrink_step: offset/frame/wrap=%b required=%b",
               {bus_a.dbg_offset, bus_a.o_frame, bus_a.o_wrap}, {3'd1, 1'b1, 1'b0});
    end
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      for (int k = 1; k <= 4; k++) begin
        step(1);
        n_cmp++;
        if (k < 4) begin
          if ({bus_a.o_an, bus_a.o_seg} !== {exp_an, dig_seg[(1 + d) % 3]}) begin
            n_bad++;
            $display("FAIL len3_lit d%0d k%0d: an/seg=%b required=%b", d, k,
                     {bus_a.o_an, bus_a.o_seg}, {exp_an, dig_seg[(1 + d) % 3]});
          end
        end else if ({bus_a.o_an, bus_a.o_wrap} !== {4'hF, 1'b0}) begin
          n_bad++;
          $display("FAIL len3_slot_end d%0d: an/wrap=%b required=%b", d, {bus_a.o_an, bus_a.o_wrap}, {4'hF, 1'b0});
        end
      end
    end
    bus_a.i_len = 4'd0;
    step(1);
    n_cmp++;
    if ({bus_a.dbg_offset, bus_a.o_wrap} !== {3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL len0_clear: offset/wrap=%b required=%b", {bus_a.dbg_offset, bus_a.o_wrap}, {3'd0, 1'b0});
    end
    sync_frame(1'b0);
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      for (int k = 1; k <= 4; k++) begin
        step(1);
        n_cmp++;
        if (k < 4) begin
          if ({bus_a.o_an, bus_a.o_seg} !== {exp_an, BLK}) begin
            n_bad++;
            $display("FAIL len0_lit d%0d k%0d: an/seg=%b required=%b", d, k, {bus_a.o_an, bus_a.o_seg}, {exp_an, BLK});
          end
        end else if ({bus_a.o_an, bus_a.dbg_offset, bus_a.o_wrap} !== {4'hF, 3'd0, 1'b0}) begin
          n_bad++;
          $display("FAIL len0_slot_end d%0d: an/offset/wrap=%b required=%b", d,
                   {bus_a.o_an, bus_a.dbg_offset, bus_a.o_wrap}, {4'hF, 3'd0, 1'b0});
        end
      end
    end
  endtask

  task automatic test_polarity();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    write_b(3'd0, 6'h08);
    write_b(3'd6, 6'h01);
    write_b(3'd7, 6'h01);
    bus_b.i_len = 4'd6;
    sync_frame(1'b1);
    for (int d = 0; d < 4; d++) begin
      exp_an  = 4'b0001 << d;
      exp_seg = (d == 0) ? 7'h7F : 7'h00;
      for (int k = 1; k <= 4; k++) begin
        step(1);
        n_cmp++;
        if (k < 4) begin
          if ({bus_b.o_an, bus_b.o_seg} !== {exp_an, exp_seg}) begin
            n_bad++;
            $display("FAIL polarity_lit d%0d k%0d: an/seg=%b required=%b", d, k,
                     {bus_b.o_an, bus_b.o_seg}, {exp_an, exp_seg});
          end
        end else if (bus_b.o_an !== 4'h0) begin
          n_bad++;
          $display("FAIL polarity_slot_end d%0d: an=%b required=0000", d, bus_b.o_an);
        end
      end
    end
  endtask

  // Sequence and final report
  initial begin
    init_inputs();
    test_reset();
    test_static_help();
    test_static_short();
    test_scroll();
    test_shrink();
    test_polarity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
